// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Contents:
//   arb_state_t - arbiter sequencing state
//   owner_t     - which pipeline requester wins arbitration in a given cycle
//   TO_W        - timeout counter width for the default TIMEOUT
//   IF_BE_ALL   - fetch byte-enable pattern (all lanes) for the default data width
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    localparam int TIMEOUT_DEF = 16;
    localparam int TO_W        = $clog2(TIMEOUT_DEF + 1);

    localparam int DATA_W_DEF = 32;
    localparam logic [DATA_W_DEF/8-1:0] IF_BE_ALL = {(DATA_W_DEF/8){1'b1}};

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts cycles an outstanding memory request has gone unacknowledged.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clear_i    - no request outstanding; restart the count
//   enable_i   - request outstanding and not acknowledged this cycle
//   expired_o  - this is the TIMEOUT-th unacknowledged cycle; abort on this edge
module mem_timeout_ctr
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Saturating count of waiting cycles so a stuck enable can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // Fires in the last waiting cycle so the request is high exactly TIMEOUT cycles.
    assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and load/store (DM).
// DM has priority; after MAX_DM_STREAK consecutive contended DM grants IF is forced through.
// Each access runs a req/ack handshake; an unacknowledged request is aborted after TIMEOUT.
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   if_req/if_addr             - fetch request; if_rdata/if_done/if_stall back to fetch
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata - data request; dm_rdata/dm_done/dm_stall back
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata - registered memory command
//   mem_ack/mem_rdata          - memory completion and read data
//   bus_err                    - one-cycle pulse when an access is aborted by timeout
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_done,
    output logic                dm_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_err
);

    localparam int BE_W = DATA_W / 8;
    localparam int ST_W = $clog2(MAX_DM_STREAK + 1);
    localparam logic [BE_W-1:0] IF_BE = {BE_W{1'b1}};

    arb_state_t        state_q;
    logic [ST_W-1:0]   streak_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [BE_W-1:0]   mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_done_q;
    logic              dm_done_q;
    logic              bus_err_q;

    owner_t            winner_s;
    logic              expired_s;
    logic              to_clear_s;
    logic              to_enable_s;

    assign to_clear_s  = ~mem_req_q;
    assign to_enable_s = mem_req_q & ~mem_ack;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (reset),
        .clear_i   (to_clear_s),
        .enable_i  (to_enable_s),
        .expired_o (expired_s)
    );

    // Winner among the live requests; a req still high in its done cycle counts as a fresh request.
    always_comb begin
        winner_s = OWN_NONE;
        case ({if_req, dm_req})
            2'b10:   winner_s = OWN_IF;
            2'b01:   winner_s = OWN_DM;
            2'b11:   winner_s = (streak_q == ST_W'(MAX_DM_STREAK)) ? OWN_IF : OWN_DM;
            default: winner_s = OWN_NONE;
        endcase
    end

    // Arbiter FSM: grant and register the command, hold until ack or timeout, then complete.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    case (winner_s)
                        OWN_IF: begin
                            state_q     <= BUSY_IF;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b0;
                            mem_be_q    <= IF_BE;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                            streak_q    <= '0;
                        end
                        OWN_DM: begin
                            state_q     <= BUSY_DM;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= dm_we;
                            mem_be_q    <= dm_be;
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_wdata;
                            // Only a grant that made IF wait lengthens the streak.
                            if (if_req && (streak_q != ST_W'(MAX_DM_STREAK))) begin
                                streak_q <= streak_q + ST_W'(1);
                            end else begin
                                streak_q <= streak_q;
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                        end
                    endcase
                end
                BUSY_IF, BUSY_DM: begin
                    // An ack in the expiry cycle is a normal completion.
                    if (mem_ack || expired_s) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= '0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        bus_err_q   <= ~mem_ack;
                        if (state_q == BUSY_IF) begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= mem_ack ? mem_rdata : '0;
                        end else begin
                            dm_done_q <= 1'b1;
                            if (!mem_ack) begin
                                dm_rdata_q <= '0;
                            end else if (!mem_we_q) begin
                                dm_rdata_q <= mem_rdata;
                            end else begin
                                dm_rdata_q <= dm_rdata_q;
                            end
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign bus_err   = bus_err_q;

    assign if_stall  = if_req & ~if_done_q;
    assign dm_stall  = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        bus_err;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .dm_stall  (dm_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    typedef struct {
        bit          is_dm;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          ack_lat  = 1;       // 0 = memory never acknowledges
    logic [31:0] rd_val   = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model: acknowledges in the ack_lat-th cycle that mem_req is high.
    initial begin
        int req_cnt;
        req_cnt   = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                req_cnt   = req_cnt + 1;
                mem_ack   = (ack_lat != 0) && (req_cnt == ack_lat);
                mem_rdata = mem_ack ? rd_val : 32'h0;
            end else begin
                req_cnt   = 0;
                mem_ack   = 1'b0;
                mem_rdata = 32'h0;
            end
        end
    end

    // Scoreboard: every done pulse pops the oldest expected completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_done || dm_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {62'h0, if_done, dm_done}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_owner", {63'h0, dm_done}, {63'h0, e.is_dm});
                    check("single_done", {63'h0, if_done & dm_done}, 64'h0);
                    check("done_rdata", {32'h0, (dm_done ? dm_rdata : if_rdata)}, {32'h0, e.rdata});
                    check("done_bus_err", {63'h0, bus_err}, {63'h0, e.err});
                end
            end else if (bus_err) begin
                check("stray_bus_err", {63'h0, bus_err}, 64'h0);
            end
        end
    end

    task automatic wait_done(input bit is_dm, input string tag, input logic [68:0] exp_cmd,
                             input int exp_cyc);
        bit got;
        bit cmd_ok;
        int n;
        got    = 1'b0;
        cmd_ok = 1'b1;
        n      = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (mem_req) begin
                n++;
                if ({mem_we, mem_be, mem_addr, mem_wdata} !== exp_cmd) cmd_ok = 1'b0;
            end
            if (is_dm ? dm_done : if_done) got = 1'b1;
        end
        check({tag, "_done"}, {63'h0, got}, 64'h1);
        check({tag, "_cmd_held"}, {63'h0, cmd_ok}, 64'h1);
        check({tag, "_req_cycles"}, n, exp_cyc);
    endtask

    task automatic run_access(input bit is_dm, input bit we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                              input logic [31:0] rv, input logic [31:0] exp_rd, input bit exp_err,
                              input string tag);
        logic [68:0] cmd;
        @(negedge clk);
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_be = be; dm_addr = addr; dm_wdata = wdata;
            cmd = {we, be, addr, wdata};
        end else begin
            if_req = 1'b1; if_addr = addr;
            cmd = {1'b0, 4'hF, addr, 32'h0};
        end
        ack_lat = lat;
        rd_val  = rv;
        exp_q.push_back('{is_dm, exp_rd, exp_err});
        wait_done(is_dm, tag, cmd, exp_err ? TIMEOUT : lat);
        if (is_dm) dm_req = 1'b0;
        else if_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int ng;
        int first_c;
        int last_c;
        logic prev_req;

        reset = 1'b0; if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_outs", {mem_req, mem_we, mem_be, if_done, dm_done, bus_err, if_stall, dm_stall}, 64'h0);
        check("reset_rdata", {if_rdata, dm_rdata}, 64'h0);
        check("reset_cmd", {mem_addr, mem_wdata}, 64'h0);
        reset = 1'b1;

        // IF-only read with single-cycle memory latency.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0010; ack_lat = 1; rd_val = 32'h0000_0093;
        exp_q.push_back('{1'b0, 32'h0000_0093, 1'b0});
        #1 check("if_stall_t0", {63'h0, if_stall}, 64'h1);
        @(negedge clk);
        check("if_cmd_t1", {27'h0, mem_req, mem_we, mem_be, mem_addr}, {27'h0, 1'b1, 1'b0, 4'hF, 32'h10});
        check("if_stall_t1", {62'h0, if_stall, if_done}, {62'h0, 1'b1, 1'b0});
        @(negedge clk);
        check("if_done_t2", {63'h0, if_done}, 64'h1);
        check("if_stall_t2", {63'h0, if_stall}, 64'h0);
        check("if_rdata_t2", {32'h0, if_rdata}, {32'h0, 32'h93});
        if_req = 1'b0;
        @(negedge clk);
        check("if_no_reissue", {63'h0, mem_req}, 64'h0);

        // Load, then stores that must leave dm_rdata untouched (including be = 0).
        run_access(1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 3, 32'h55AA_1234, 32'h55AA_1234, 1'b0, "dm_load");
        run_access(1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 3, 32'hFFFF_FFFF, 32'h55AA_1234, 1'b0, "dm_store");
        run_access(1'b1, 1'b1, 4'b0000, 32'h104, 32'h1357_9BDF, 2, 32'hFFFF_FFFF, 32'h55AA_1234, 1'b0, "dm_store_be0");

        // Continuous contention: DM x4 then a forced IF grant, twice.
        @(negedge clk);
        if_addr = 32'h1000; dm_addr = 32'h2000; dm_we = 1'b0; dm_be = 4'hF; dm_wdata = 32'h0;
        ack_lat = 1; rd_val = 32'hCAFE_0000;
        if_req = 1'b1; dm_req = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back('{((i % 5) != 4), 32'hCAFE_0000, 1'b0});
        prev_req = 1'b0; ng = 0; first_c = 0; last_c = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                check($sformatf("grant%0d_is_dm", ng), {63'h0, (mem_addr == 32'h2000)},
                      {63'h0, ((ng % 5) != 4)});
                if (ng == 0) first_c = c;
                last_c = c;
                ng++;
            end
            prev_req = mem_req;
        end
        if_req = 1'b0; dm_req = 1'b0;
        check("grant_count", ng, 10);
        check("grant_span", last_c - first_c, 18);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);

        // Timeouts, recovery and the ack-at-expiry corner.
        run_access(1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 0, 32'h0, 32'h0, 1'b1, "dm_timeout");
        run_access(1'b1, 1'b0, 4'hF, 32'h404, 32'h0, 2, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, "dm_after_to");
        run_access(1'b0, 1'b0, 4'hF, 32'h500, 32'h0, 0, 32'h0, 32'h0, 1'b1, "if_timeout");
        run_access(1'b0, 1'b0, 4'hF, 32'h504, 32'h0, 1, 32'hABCD_0001, 32'hABCD_0001, 1'b0, "if_after_to");
        run_access(1'b1, 1'b0, 4'hF, 32'h600, 32'h0, TIMEOUT, 32'h0000_1234, 32'h0000_1234, 1'b0, "ack_at_expiry");

        // Reset two cycles into a DM access, then the held request is re-issued.
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h300; dm_wdata = 32'h0; ack_lat = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_busy", {63'h0, mem_req}, 64'h1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_outs", {mem_req, mem_we, mem_be, if_done, dm_done, bus_err}, 64'h0);
        check("rst_async_rdata", {if_rdata, dm_rdata}, 64'h0);
        check("rst_async_cmd", {mem_addr, mem_wdata}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_no_done", {63'h0, dm_done}, 64'h0);
        ack_lat = 1; rd_val = 32'h7777_0000;
        exp_q.push_back('{1'b1, 32'h7777_0000, 1'b0});
        reset = 1'b1;
        wait_done(1'b1, "rst_reissue", {1'b0, 4'hF, 32'h300, 32'h0}, 1);
        dm_req = 1'b0;

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
